// File: rtl/tdm_demux8.sv
// tdm_demux8: receive side of a time-division serial link.
// Rebuilds an N_CH-bit parallel word from one bit per slot (slot 0 first)
// and presents it through a single-entry valid/ready output register.
// Sticky flags report a frame_sync at a nonzero slot and dropped words.
module tdm_demux8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [SEL_W-1:0] slot,
  output logic [N_CH-1:0]  d_out,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             sync_err,
  output logic             overrun
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_slot;
  logic [N_CH-1:0]  r_shadow;
  logic [N_CH-1:0]  r_d_out;
  logic             r_d_valid;
  logic             r_sync_err;
  logic             r_overrun;

  logic             w_last;
  logic             w_free;
  logic             w_take;
  logic             w_misalign;
  logic [N_CH-1:0]  w_word;
  logic [N_CH-1:0]  w_restart;

  // The completing bit goes straight into the top of the word, so the output
  // can load on the same edge that receives the last slot.
  assign w_last     = (r_slot == SEL_W'(N_CH - 1));
  assign w_take     = r_d_valid && d_ready;
  assign w_free     = !r_d_valid || d_ready;
  assign w_misalign = frame_sync && (r_slot != {SEL_W{1'b0}});
  assign w_word     = {din, r_shadow[N_CH-2:0]};
  assign w_restart  = {{(N_CH-1){1'b0}}, din};

  // Frame state, shadow word, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_slot     <= {SEL_W{1'b0}};
      r_shadow   <= {N_CH{1'b0}};
      r_d_out    <= {N_CH{1'b0}};
      r_d_valid  <= 1'b0;
      r_sync_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // Consumer handshake; a word completing this edge overrides below.
      if (w_take) begin
        r_d_valid <= 1'b0;
      end

      if (din_valid) begin
        case (r_state)
          ST_IDLE: begin
            // Bits before the first frame_sync carry no alignment and are dropped.
            if (frame_sync) begin
              r_shadow <= w_restart;
              r_slot   <= SEL_W'(1);
              r_state  <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (w_misalign) begin
              // Realign on the sync bit; the partial word is discarded.
              r_sync_err <= 1'b1;
              r_shadow   <= w_restart;
              r_slot     <= SEL_W'(1);
            end else begin
              r_shadow[r_slot] <= din;
              r_slot           <= r_slot + SEL_W'(1);
              if (w_last) begin
                if (w_free) begin
                  r_d_out   <= w_word;
                  r_d_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_slot  <= {SEL_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign slot     = r_slot;
  assign d_out    = r_d_out;
  assign d_valid  = r_d_valid;
  assign sync_err = r_sync_err;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: table-driven frames plus hand-written corner sequences.
// Expected words are queued when a frame is driven and compared when the
// DUT hands a word to the consumer.
module tb_tdm_demux8;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [2:0] slot;
  logic [7:0] d_out;
  logic       d_valid;
  logic       d_ready;
  logic       sync_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  tdm_demux8 #(.N_CH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .slot       (slot),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .sync_err   (sync_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;     // bits[i] is sent in slot i
    bit         sync;     // frame_sync on slot 0
    bit         gaps;     // random idle cycles between bits
    logic [7:0] exp_dout; // word expected on d_out
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: score a handshake about to happen, then advance to 1 ns after the edge.
  task automatic tick();
    logic [7:0] exp;
    if (d_valid === 1'b1 && d_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, required no word", d_out);
      end else begin
        exp = sb_q.pop_front();
        check("handshake_word", {24'd0, d_out}, {24'd0, exp});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    din_valid  = 1'b1;
    din        = b;
    frame_sync = fs;
    tick();
    din_valid  = 1'b0;
    din        = 1'($urandom);
    frame_sync = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] bits, input bit sync, input bit gaps, input bit chk_v);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      if (chk_v && i == 7) check("valid_before_last", {31'd0, d_valid}, 32'd0);
      send_bit(bits[i], sync && (i == 0));
      check("slot_step", {29'd0, slot}, 32'((i + 1) % 8));
    end
  endtask

  initial begin
    vec_t vecs[3];
    logic [7:0] seq;

    vecs[0] = '{bits: 8'h4D, sync: 1'b1, gaps: 1'b0, exp_dout: 8'h4D};
    vecs[1] = '{bits: 8'hA5, sync: 1'b1, gaps: 1'b1, exp_dout: 8'hA5};
    vecs[2] = '{bits: 8'h3C, sync: 1'b0, gaps: 1'b1, exp_dout: 8'h3C};

    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    d_ready    = 1'b0;

    // Reset held for two clocks with random input activity.
    for (int i = 0; i < 2; i++) begin
      din        = 1'($urandom);
      din_valid  = 1'($urandom);
      frame_sync = 1'($urandom);
      tick();
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;
    check("rst_slot",     {29'd0, slot},     32'd0);
    check("rst_dout",     {24'd0, d_out},    32'd0);
    check("rst_valid",    {31'd0, d_valid},  32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    check("rst_overrun",  {31'd0, overrun},  32'd0);

    // Basic frame, then two frames with gaps (the second without frame_sync).
    d_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      sb_q.push_back(vecs[v].exp_dout);
      send_frame(vecs[v].bits, vecs[v].sync, vecs[v].gaps, 1'b1);
      check("vec_valid", {31'd0, d_valid}, 32'd1);
      check("vec_dout",  {24'd0, d_out},   {24'd0, vecs[v].exp_dout});
      check("vec_slot",  {29'd0, slot},    32'd0);
      if (v == 0) begin
        tick();
        check("basic_valid_drop", {31'd0, d_valid}, 32'd0);
      end
    end
    check("wrap_sync_err", {31'd0, sync_err}, 32'd0);
    tick();
    check("drain_valid", {31'd0, d_valid}, 32'd0);

    // Backpressure: second word is dropped and overrun latches.
    d_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check("bp_first_valid", {31'd0, d_valid}, 32'd1);
    check("bp_first_ovr",   {31'd0, overrun}, 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    check("bp_hold_dout",   {24'd0, d_out},   32'h11);
    check("bp_hold_valid",  {31'd0, d_valid}, 32'd1);
    check("bp_overrun",     {31'd0, overrun}, 32'd1);
    d_ready = 1'b1;
    tick();
    check("bp_consumed",    {31'd0, d_valid}, 32'd0);
    check("bp_dout_kept",   {24'd0, d_out},   32'h11);

    // Misaligned frame_sync at slot 3 realigns the frame.
    check("pre_sync_err", {31'd0, sync_err}, 32'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("mis_slot3", {29'd0, slot}, 32'd3);
    send_bit(1'b1, 1'b1);
    check("mis_sync_err", {31'd0, sync_err}, 32'd1);
    check("mis_slot1",    {29'd0, slot},     32'd1);
    seq = 8'b0010_1100; // slots 1..7 carry seq[1..7]
    sb_q.push_back(8'h2D);
    for (int i = 1; i < 8; i++) send_bit(seq[i], 1'b0);
    check("mis_valid", {31'd0, d_valid}, 32'd1);
    check("mis_dout",  {24'd0, d_out},   32'h2D);
    tick();
    check("mis_drain", {31'd0, d_valid}, 32'd0);

    // Reset in the middle of a frame with a word pending.
    d_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    check("mid_pending", {24'd0, d_out}, 32'h5A);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    check("mid_slot5", {29'd0, slot}, 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_slot",  {29'd0, slot},     32'd0);
    check("mid_rst_valid", {31'd0, d_valid},  32'd0);
    check("mid_rst_dout",  {24'd0, d_out},    32'd0);
    check("mid_rst_serr",  {31'd0, sync_err}, 32'd0);
    check("mid_rst_ovr",   {31'd0, overrun},  32'd0);
    d_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
    check("idle_ignore_slot",  {29'd0, slot},    32'd0);
    check("idle_ignore_valid", {31'd0, d_valid}, 32'd0);
    sb_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    check("resync_valid", {31'd0, d_valid}, 32'd1);
    check("resync_dout",  {24'd0, d_out},   32'hC3);
    tick();
    check("final_valid", {31'd0, d_valid}, 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
